frame_fill_sequencer: RTL and testbench

FRAME_FILL_SEQUENCER -- requirements
Module: frame_fill_sequencer

---
 rtl/frame_fill_sequencer.sv | 139 +++++++++++++
 tb/tb_frame_fill_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fill_sequencer.sv
// Streams one full frame of solid colour or image-ROM pixels to the LT24 display.
// Three cycles per pixel (ADDR, DATA, WRITE); the WRITE beat stalls while pixelReady is low.
module frame_fill_sequencer #(
    parameter int LCD_WIDTH  = 240,
    parameter int LCD_HEIGHT = 320
) (
    input  logic        clock,
    input  logic        resetApp_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  mode,
    output logic        busy,
    output logic        frameDone,
    output logic [16:0] romAddr,
    output logic [1:0]  romSel,
    input  logic [15:0] romData,
    output logic [7:0]  xAddr,
    output logic [8:0]  yAddr,
    output logic [15:0] pixelData,
    output logic        pixelWrite,
    input  logic        pixelReady
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE,
        DONE
    } state_t;

    localparam logic [7:0] X_LAST = 8'(LCD_WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(LCD_HEIGHT - 1);

    state_t      state;
    logic [3:0]  mode_q;
    logic [7:0]  x;
    logic [8:0]  y;

    logic        last_x;
    logic        last_pixel;
    logic [7:0]  x_nxt;
    logic [8:0]  y_nxt;
    logic [16:0] addr_nxt;
    logic        use_rom;
    logic        start_rom;
    logic [15:0] solid;

    always_comb begin
        last_x     = (x == X_LAST);
        last_pixel = last_x && (y == Y_LAST);
        x_nxt      = last_x ? 8'd0 : x + 8'd1;
        y_nxt      = last_x ? y + 9'd1 : y;
        addr_nxt   = 17'(y_nxt) * 17'(LCD_WIDTH) + 17'(x_nxt);
        use_rom    = (mode_q >= 4'd9) && (mode_q <= 4'd11);
        start_rom  = (mode >= 4'd9) && (mode <= 4'd11);
    end

    always_comb begin
        case (mode_q)
            4'd1:    solid = 16'h4DC4;
            4'd2:    solid = 16'hF920;
            4'd4:    solid = 16'h24F7;
            4'd8:    solid = 16'hFDA0;
            default: solid = 16'h0000;
        endcase
    end

    // romAddr is loaded on entry to ADDR so the synchronous ROM has its data ready during DATA.
    always_ff @(posedge clock or negedge resetApp_n) begin
        if (!resetApp_n) begin
            state      <= IDLE;
            mode_q     <= 4'd0;
            x          <= 8'd0;
            y          <= 9'd0;
            busy       <= 1'b0;
            frameDone  <= 1'b0;
            romAddr    <= 17'd0;
            romSel     <= 2'd0;
            xAddr      <= 8'd0;
            yAddr      <= 9'd0;
            pixelData  <= 16'd0;
            pixelWrite <= 1'b0;
        end else if (state != IDLE && abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frameDone  <= 1'b0;
            pixelWrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frameDone <= 1'b0;
                    if (start && !abort) begin
                        mode_q  <= mode;
                        romSel  <= start_rom ? 2'(mode - 4'd9) : 2'd0;
                        x       <= 8'd0;
                        y       <= 9'd0;
                        romAddr <= 17'd0;
                        busy    <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    state <= DATA;
                end
                DATA: begin
                    pixelData  <= use_rom ? romData : solid;
                    xAddr      <= x;
                    yAddr      <= y;
                    pixelWrite <= 1'b1;
                    state      <= WRITE;
                end
                WRITE: begin
                    if (pixelReady) begin
                        pixelWrite <= 1'b0;
                        if (last_pixel) begin
                            frameDone <= 1'b1;
                            state     <= DONE;
                        end else begin
                            x       <= x_nxt;
                            y       <= y_nxt;
                            romAddr <= addr_nxt;
                            state   <= ADDR;
                        end
                    end
                end
                DONE: begin
                    frameDone <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_fill_sequencer.sv
// Bench for frame_fill_sequencer: a small-frame instance checked beat-by-beat against a queue model,
// plus a full-size instance for address arithmetic and abort behaviour.
module tb_frame_fill_sequencer;

    localparam int SW = 8;
    localparam int SH = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetApp_n;

    logic        s_start, s_abort, s_busy, s_done, s_wr, s_ready;
    logic [3:0]  s_mode;
    logic [16:0] s_romAddr;
    logic [1:0]  s_romSel;
    logic [15:0] s_romData = 16'd0;
    logic [7:0]  s_x;
    logic [8:0]  s_y;
    logic [15:0] s_pix;

    logic        l_start, l_abort, l_busy, l_done, l_wr, l_ready;
    logic [3:0]  l_mode;
    logic [16:0] l_romAddr;
    logic [1:0]  l_romSel;
    logic [15:0] l_romData = 16'd0;
    logic [7:0]  l_x;
    logic [8:0]  l_y;
    logic [15:0] l_pix;

    frame_fill_sequencer #(.LCD_WIDTH(SW), .LCD_HEIGHT(SH)) dut_s (
        .clock(clock), .resetApp_n(resetApp_n), .start(s_start), .abort(s_abort),
        .mode(s_mode), .busy(s_busy), .frameDone(s_done), .romAddr(s_romAddr),
        .romSel(s_romSel), .romData(s_romData), .xAddr(s_x), .yAddr(s_y),
        .pixelData(s_pix), .pixelWrite(s_wr), .pixelReady(s_ready)
    );

    frame_fill_sequencer dut_l (
        .clock(clock), .resetApp_n(resetApp_n), .start(l_start), .abort(l_abort),
        .mode(l_mode), .busy(l_busy), .frameDone(l_done), .romAddr(l_romAddr),
        .romSel(l_romSel), .romData(l_romData), .xAddr(l_x), .yAddr(l_y),
        .pixelData(l_pix), .pixelWrite(l_wr), .pixelReady(l_ready)
    );

    // Synchronous image ROMs whose contents equal their address.
    always @(posedge clock) begin
        s_romData <= s_romAddr[15:0];
        l_romData <= l_romAddr[15:0];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_cmp(input string name, input int act, input int req);
        total++;
        bad++;
        $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [15:0] d;
    } beat_t;

    beat_t exp_q[$];
    beat_t e_cur;
    int    beats = 0;
    int    done_cnt = 0;
    int    l_done_cnt = 0;

    function automatic logic [15:0] colour(input logic [3:0] m, input int xi, input int yi, input int w);
        case (m)
            4'd1:             return 16'h4DC4;
            4'd2:             return 16'hF920;
            4'd4:             return 16'h24F7;
            4'd8:             return 16'hFDA0;
            4'd9, 4'd10, 4'd11: return 16'(yi * w + xi);
            default:          return 16'h0000;
        endcase
    endfunction

    task automatic fill(input logic [3:0] m);
        for (int yi = 0; yi < SH; yi++)
            for (int xi = 0; xi < SW; xi++)
                exp_q.push_back('{xi, yi, colour(m, xi, yi, SW)});
    endtask

    // pixelReady driver: held low for stall_left WRITE cycles at (stall_x, stall_y).
    int stall_x = 0;
    int stall_y = 0;
    int stall_left = 0;
    initial begin
        s_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            if (s_wr && s_x == stall_x && s_y == stall_y && stall_left > 0) begin
                s_ready = 1'b0;
                stall_left--;
            end else begin
                s_ready = 1'b1;
            end
        end
    end

    // Compare process for the small instance.
    logic        p_wr = 1'b0, p_acc = 1'b0, p_ab = 1'b0, p_rst = 1'b0, p_done = 1'b0;
    logic [7:0]  p_x = 8'd0;
    logic [8:0]  p_y = 9'd0;
    logic [15:0] p_pix = 16'd0;
    always @(negedge clock) begin
        if (resetApp_n && p_rst && p_wr && !p_acc && !p_ab) begin
            chk("hold_write", s_wr, 1);
            chk("hold_beat", {s_x, s_y, s_pix}, {p_x, p_y, p_pix});
        end
        if (resetApp_n) begin
            if (s_wr && s_ready && !s_abort) begin
                if (exp_q.size() == 0) begin
                    fail_cmp("beat_unexpected", int'(s_x), -1);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("beat", {s_x, s_y, s_pix}, {8'(e_cur.x), 9'(e_cur.y), e_cur.d});
                    beats++;
                end
            end
            if (s_done) begin
                chk("done_single", p_done, 0);
                chk("done_all_beats", exp_q.size(), 0);
                done_cnt++;
            end
        end
        p_wr  = s_wr;
        p_acc = s_wr && s_ready;
        p_ab  = s_abort;
        p_rst = resetApp_n;
        p_done = s_done;
        p_x   = s_x;
        p_y   = s_y;
        p_pix = s_pix;
    end

    always @(negedge clock) if (l_done) l_done_cnt++;

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic start_small(input logic [3:0] m);
        fill(m);
        s_mode  = m;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
    endtask

    task automatic start_large(input logic [3:0] m);
        l_mode  = m;
        l_start = 1'b1;
        step();
        l_start = 1'b0;
    endtask

    task automatic wait_wr_at(input bit lg, input int xi, input int yi, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (lg ? (l_wr && l_x == xi && l_y == yi) : (s_wr && s_x == xi && s_y == yi)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_cmp("wait_write_timeout", xi, yi);
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (s_done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_cmp("done_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    logic [3:0] table_modes [5] = '{4'd5, 4'd8, 4'd4, 4'd10, 4'd0};

    initial begin
        int k;
        int at;
        int n;
        resetApp_n = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_mode = 4'd0;
        l_start = 1'b0; l_abort = 1'b0; l_mode = 4'd0; l_ready = 1'b1;

        repeat (3) @(negedge clock);
        chk("reset_ctrl", {s_busy, s_done, s_wr, s_romSel}, 0);
        chk("reset_data", {s_romAddr, s_x, s_y, s_pix}, 0);
        step();
        resetApp_n = 1'b1;
        repeat (5) step();
        chk("no_autostart", {s_busy, s_wr, l_busy, l_wr}, 0);

        // Red frame with pixelReady held high: timing and first beat.
        k = cyc;
        start_small(4'd2);
        s_mode = 4'd0;
        wait_wr_at(1'b0, 0, 0, 10);
        chk("first_beat_red", {s_x, s_y, s_pix}, {8'd0, 9'd0, 16'hF920});
        wait_done(400, at);
        chk("frame_cycles", at - k, 3 * SW * SH + 1);
        @(negedge clock);
        chk("idle_after_done", {s_busy, s_done}, 0);
        chk("frames_done_1", done_cnt, 1);
        chk("beats_frame_1", beats, SW * SH);

        // Green frame: 10-cycle stall at (3,0), then an ignored mid-frame start with mode 4.
        stall_x = 3; stall_y = 0; stall_left = 10;
        start_small(4'd1);
        wait_wr_at(1'b0, 3, 0, 40);
        chk("stall_beat", {s_x, s_y, s_pix}, {8'd3, 9'd0, 16'h4DC4});
        n = 0;
        while (s_wr && n < 40) begin
            n++;
            step();
        end
        chk("stall_cycles", n, 11);
        s_mode = 4'd4;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        wait_done(400, at);
        step();
        chk("frames_done_2", done_cnt, 2);

        foreach (table_modes[i]) begin
            start_small(table_modes[i]);
            @(negedge clock);
            chk("rom_select", s_romSel, (table_modes[i] == 4'd10) ? 1 : 0);
            wait_done(200, at);
            step();
        end
        chk("frames_done_7", done_cnt, 7);

        // Abort and start together while idle.
        s_start = 1'b1; s_abort = 1'b1;
        step();
        s_start = 1'b0; s_abort = 1'b0;
        repeat (3) @(negedge clock);
        chk("start_abort_idle", {s_busy, s_wr}, 0);

        // Abort coinciding with acceptance of pixel 20, then restart.
        start_small(4'd8);
        wait_wr_at(1'b0, 4, 2, 200);
        s_abort = 1'b1;
        step();
        s_abort = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("abort_stops", {s_wr, s_busy, s_done}, 0);
        repeat (3) @(negedge clock);
        chk("abort_no_done", done_cnt, 7);
        start_small(4'd8);
        wait_wr_at(1'b0, 0, 0, 10);
        chk("restart_origin", {s_x, s_y, s_pix}, {8'd0, 9'd0, 16'hFDA0});
        wait_done(200, at);
        step();
        chk("frames_done_8", done_cnt, 8);

        // Full-size instance: ROM addressing, romSel, abort at pixel 100, restart.
        start_large(4'd9);
        wait_wr_at(1'b1, 5, 1, 1000);
        chk("rom_beat_5_1", {l_pix, l_romSel}, {16'h00F5, 2'd0});
        l_abort = 1'b1;
        step();
        l_abort = 1'b0;
        start_large(4'd11);
        @(negedge clock);
        chk("rom_select_2", l_romSel, 2);
        wait_wr_at(1'b1, 100, 0, 500);
        chk("rom_beat_100", l_pix, 16'h0064);
        l_abort = 1'b1;
        step();
        l_abort = 1'b0;
        @(negedge clock);
        chk("large_abort", {l_wr, l_busy}, 0);
        start_large(4'd2);
        wait_wr_at(1'b1, 0, 0, 10);
        chk("large_restart", {l_x, l_y, l_pix}, {8'd0, 9'd0, 16'hF920});
        l_abort = 1'b1;
        step();
        l_abort = 1'b0;
        chk("large_no_done", l_done_cnt, 0);

        // Asynchronous reset in the middle of a WRITE.
        start_small(4'd2);
        wait_wr_at(1'b0, 2, 0, 50);
        #1 resetApp_n = 1'b0;
        #1;
        chk("async_reset_ctrl", {s_busy, s_done, s_wr, s_romSel}, 0);
        chk("async_reset_data", {s_romAddr, s_x, s_y, s_pix}, 0);
        exp_q.delete();
        @(negedge clock);
        #2 resetApp_n = 1'b1;
        repeat (5) @(negedge clock);
        chk("post_reset_idle", {s_busy, s_done, s_wr, s_romSel, s_romAddr, s_x, s_y, s_pix}, 0);
        chk("frames_done_final", done_cnt, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
